// File: rtl/xgmii_rate_ctrl.sv
// XGMII rate adaptation front end: samples the XGMII word once every D
// clocks (D from speed_sel), tracks frame boundaries, reports frame byte
// counts and runs a simple link-fault qualification state machine.
//
// state | meaning
// ------+-------------------------------------------------------------
// FAIL  | link down, waiting for a fault-free sample
// RCVR  | recovering, counting fault-free samples down to zero
// GOOD  | link up, linkup asserted one clock later
module xgmii_rate_ctrl #(
    parameter int BCNT_W    = 16,
    parameter int MAX_FRAME = 9600,
    parameter int LINK_CNT  = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        speed_sel,
    input  logic [63:0]       data_in,
    input  logic [7:0]        ctrl_in,
    output logic [63:0]       data_out,
    output logic [7:0]        ctrl_out,
    output logic              we,
    output logic [BCNT_W-1:0] byte_cnt,
    output logic              sof4,
    output logic              bcnt_we,
    output logic              len_err,
    output logic              linkup,
    output logic [7:0]        fault_cnt
);

    localparam logic [BCNT_W-1:0] ACC_S0 = BCNT_W'(8);
    localparam logic [BCNT_W-1:0] ACC_S4 = BCNT_W'(4);

    typedef enum logic [1:0] {ST_FAIL, ST_RCVR, ST_GOOD} link_st_t;

    logic [1:0]        r_spd;
    logic [3:0]        r_ph;
    logic              r_open;
    logic              r_cur_sof4;
    logic [BCNT_W-1:0] r_acc;
    link_st_t          r_state;
    logic [15:0]       r_link_cnt;

    logic [3:0]        w_div_m1;
    logic              w_spd_chg;
    logic              w_sample;
    logic              w_s0;
    logic              w_s4;
    logic              w_t_hit;
    logic [2:0]        w_t_lane;
    logic              w_fault;
    logic [BCNT_W-1:0] w_acc_t;
    logic [BCNT_W-1:0] w_acc_8;

    function automatic logic [BCNT_W-1:0] sat_add(input logic [BCNT_W-1:0] a,
                                                  input logic [3:0] inc);
        logic [BCNT_W:0] s;
        s = {1'b0, a} + {{(BCNT_W-3){1'b0}}, inc};
        sat_add = s[BCNT_W] ? {BCNT_W{1'b1}} : s[BCNT_W-1:0];
    endfunction

    function automatic logic len_bad(input logic [BCNT_W-1:0] c);
        len_bad = (32'(c) > 32'(MAX_FRAME)) || (32'(c) < 32'd64);
    endfunction

    // Divider select and per-word control character decode
    always_comb begin
        case (speed_sel)
            2'b00:   w_div_m1 = 4'd0;
            2'b01:   w_div_m1 = 4'd1;
            2'b10:   w_div_m1 = 4'd3;
            default: w_div_m1 = 4'd9;
        endcase
        w_spd_chg = (speed_sel != r_spd);
        w_sample  = (r_ph == 4'd0) && !w_spd_chg;
        w_s0      = ctrl_in[0] && (data_in[7:0] == 8'hFB);
        w_s4      = ctrl_in[4] && (data_in[39:32] == 8'hFB);
        w_fault   = (ctrl_in[0] && (data_in[7:0] == 8'h9C)) ||
                    (ctrl_in[4] && (data_in[39:32] == 8'h9C));
        // scan downward so the lowest /T/ lane wins
        w_t_hit   = 1'b0;
        w_t_lane  = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (ctrl_in[k] && (data_in[8*k +: 8] == 8'hFD)) begin
                w_t_hit  = 1'b1;
                w_t_lane = 3'(k);
            end
        end
        w_acc_t = sat_add(r_acc, {1'b0, w_t_lane});
        w_acc_8 = sat_add(r_acc, 4'd8);
    end

    // Phase counter; a speed change restarts it so the next cycle samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_spd <= 2'b00;
            r_ph  <= 4'd0;
        end else begin
            r_spd <= speed_sel;
            if (w_spd_chg || (r_ph >= w_div_m1))
                r_ph <= 4'd0;
            else
                r_ph <= r_ph + 4'd1;
        end
    end

    // Sampled data/control registers, held between sample cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= 64'h0707070707070707;
            ctrl_out <= 8'hFF;
        end else if (w_sample) begin
            data_out <= data_in;
            ctrl_out <= ctrl_in;
        end
    end

    // Frame tracking, byte accumulation and frame-end reporting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_open     <= 1'b0;
            r_acc      <= '0;
            r_cur_sof4 <= 1'b0;
            we         <= 1'b0;
            byte_cnt   <= '0;
            sof4       <= 1'b0;
            bcnt_we    <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            we      <= 1'b0;
            bcnt_we <= 1'b0;
            len_err <= 1'b0;
            if (w_spd_chg) begin
                r_open <= 1'b0;
                r_acc  <= '0;
            end else if (w_sample) begin
                we <= r_open | w_s0 | w_s4 | w_t_hit;
                if (r_open && w_t_hit) begin
                    bcnt_we  <= 1'b1;
                    byte_cnt <= w_acc_t;
                    len_err  <= len_bad(w_acc_t);
                    sof4     <= r_cur_sof4;
                    if (w_s4 && !w_t_lane[2]) begin
                        r_acc      <= ACC_S4;
                        r_cur_sof4 <= 1'b1;
                    end else begin
                        r_open <= 1'b0;
                        r_acc  <= '0;
                    end
                end else if (r_open && (w_s0 || w_s4)) begin
                    // start without terminate: old frame is reported as bad
                    bcnt_we    <= 1'b1;
                    byte_cnt   <= r_acc;
                    len_err    <= 1'b1;
                    sof4       <= r_cur_sof4;
                    r_acc      <= w_s0 ? ACC_S0 : ACC_S4;
                    r_cur_sof4 <= !w_s0;
                end else if (r_open) begin
                    r_acc <= w_acc_8;
                end else if (w_s0) begin
                    r_open     <= 1'b1;
                    r_acc      <= ACC_S0;
                    r_cur_sof4 <= 1'b0;
                    sof4       <= 1'b0;
                end else if (w_s4) begin
                    r_open     <= 1'b1;
                    r_acc      <= ACC_S4;
                    r_cur_sof4 <= 1'b1;
                    sof4       <= 1'b1;
                end
            end
        end
    end

    // Link qualification FSM with registered linkup and fault counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_FAIL;
            r_link_cnt <= 16'd0;
            linkup     <= 1'b0;
            fault_cnt  <= 8'd0;
        end else begin
            linkup <= (r_state == ST_GOOD);
            if (w_sample) begin
                case (r_state)
                    ST_FAIL: begin
                        if (!w_fault) begin
                            r_state    <= ST_RCVR;
                            r_link_cnt <= 16'(LINK_CNT);
                        end
                    end
                    ST_RCVR: begin
                        if (w_fault) begin
                            r_state <= ST_FAIL;
                        end else if (r_link_cnt <= 16'd1) begin
                            r_state    <= ST_GOOD;
                            r_link_cnt <= 16'd0;
                        end else begin
                            r_link_cnt <= r_link_cnt - 16'd1;
                        end
                    end
                    ST_GOOD: begin
                        if (w_fault) begin
                            r_state <= ST_FAIL;
                            if (fault_cnt != 8'hFF)
                                fault_cnt <= fault_cnt + 8'd1;
                        end
                    end
                    default: r_state <= ST_FAIL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xgmii_rate_ctrl.sv
// Bench for xgmii_rate_ctrl: directed frame scenarios plus randomized
// traffic, all checked cycle by cycle against a behavioural model.
module tb_xgmii_rate_ctrl;

    localparam int BCNT_W    = 16;
    localparam int MAX_FRAME = 9600;
    localparam int LINK_CNT  = 30;
    localparam int CNT_MAX   = (1 << BCNT_W) - 1;
    localparam logic [63:0] IDLE_D = 64'h0707070707070707;

    logic              clk;
    logic              reset;
    logic [1:0]        speed_sel;
    logic [63:0]       data_in;
    logic [7:0]        ctrl_in;
    logic [63:0]       data_out;
    logic [7:0]        ctrl_out;
    logic              we;
    logic [BCNT_W-1:0] byte_cnt;
    logic              sof4;
    logic              bcnt_we;
    logic              len_err;
    logic              linkup;
    logic [7:0]        fault_cnt;

    xgmii_rate_ctrl #(.BCNT_W(BCNT_W), .MAX_FRAME(MAX_FRAME), .LINK_CNT(LINK_CNT)) dut (
        .clk(clk), .reset(reset), .speed_sel(speed_sel), .data_in(data_in),
        .ctrl_in(ctrl_in), .data_out(data_out), .ctrl_out(ctrl_out), .we(we),
        .byte_cnt(byte_cnt), .sof4(sof4), .bcnt_we(bcnt_we), .len_err(len_err),
        .linkup(linkup), .fault_cnt(fault_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0]  m_prev_spd;
    int          m_cyc;
    bit          m_open;
    int          m_bytes;
    bit          m_start4;
    int          m_run;
    bit          m_good;
    logic [63:0] e_data;
    logic [7:0]  e_ctrl;
    bit          e_we, e_bcnt_we, e_sof4, e_len_err, e_linkup;
    int          e_byte_cnt, e_fault_cnt;

    function automatic int div_of(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 10;
        endcase
    endfunction

    task automatic model_reset();
        m_prev_spd = 2'b00; m_cyc = 0; m_open = 0; m_bytes = 0; m_start4 = 0;
        m_run = 0; m_good = 0;
        e_data = IDLE_D; e_ctrl = 8'hFF; e_we = 0; e_bcnt_we = 0; e_sof4 = 0;
        e_len_err = 0; e_linkup = 0; e_byte_cnt = 0; e_fault_cnt = 0;
    endtask

    task automatic report(input int cnt, input bit s4f, input bit err);
        e_bcnt_we = 1; e_byte_cnt = cnt; e_sof4 = s4f; e_len_err = err;
    endtask

    task automatic model_edge(input logic [1:0] spd, input logic [63:0] d, input logic [7:0] c);
        bit chg, samp, s0, s4, flt;
        int tl, fin;
        chg  = (spd != m_prev_spd);
        samp = !chg && ((m_cyc % div_of(spd)) == 0);
        e_linkup  = m_good;
        e_we = 0; e_bcnt_we = 0; e_len_err = 0;
        if (chg) begin
            m_open = 0; m_bytes = 0; m_cyc = 0;
        end else begin
            if (samp) begin
                e_data = d; e_ctrl = c;
                s0  = c[0] && d[7:0] == 8'hFB;
                s4  = c[4] && d[39:32] == 8'hFB;
                flt = (c[0] && d[7:0] == 8'h9C) || (c[4] && d[39:32] == 8'h9C);
                tl  = -1;
                for (int j = 7; j >= 0; j--) if (c[j] && d[8*j +: 8] == 8'hFD) tl = j;
                e_we = m_open || s0 || s4 || (tl >= 0);
                if (m_open && tl >= 0) begin
                    fin = m_bytes + tl;
                    if (fin > CNT_MAX) fin = CNT_MAX;
                    report(fin, m_start4, (fin > MAX_FRAME) || (fin < 64));
                    if (s4 && tl < 4) begin m_bytes = 4; m_start4 = 1; end
                    else m_open = 0;
                end else if (m_open && (s0 || s4)) begin
                    report(m_bytes, m_start4, 1);
                    m_bytes = s0 ? 8 : 4; m_start4 = !s0;
                end else if (m_open) begin
                    m_bytes = (m_bytes + 8 > CNT_MAX) ? CNT_MAX : m_bytes + 8;
                end else if (s0 || s4) begin
                    m_open = 1; m_bytes = s0 ? 8 : 4; m_start4 = !s0; e_sof4 = !s0;
                end
                if (flt) begin
                    if (m_good && e_fault_cnt < 255) e_fault_cnt++;
                    m_run = 0; m_good = 0;
                end else begin
                    m_run++;
                    if (m_run >= LINK_CNT + 1) m_good = 1;
                end
            end
            m_cyc++;
        end
        m_prev_spd = spd;
    endtask

    // ---------------- observation ----------------
    int we_cnt, bc_cnt;
    int bc_q[$];
    bit sof_q[$];
    bit err_q[$];

    task automatic clear_obs();
        we_cnt = 0; bc_cnt = 0; bc_q.delete(); sof_q.delete(); err_q.delete();
    endtask

    task automatic compare_all();
        check("data_out", data_out, e_data);
        check("ctrl_out", 64'(ctrl_out), 64'(e_ctrl));
        check("we", 64'(we), 64'(e_we));
        check("bcnt_we", 64'(bcnt_we), 64'(e_bcnt_we));
        check("linkup", 64'(linkup), 64'(e_linkup));
        check("fault_cnt", 64'(fault_cnt), 64'(e_fault_cnt));
        if (e_bcnt_we) begin
            check("byte_cnt", 64'(byte_cnt), 64'(e_byte_cnt));
            check("sof4", 64'(sof4), 64'(e_sof4));
            check("len_err", 64'(len_err), 64'(e_len_err));
        end
    endtask

    task automatic step(input logic [1:0] spd, input logic [63:0] d, input logic [7:0] c);
        speed_sel = spd; data_in = d; ctrl_in = c;
        @(posedge clk);
        model_edge(spd, d, c);
        #1;
        compare_all();
        if (we) we_cnt++;
        if (bcnt_we) begin
            bc_cnt++; bc_q.push_back(int'(byte_cnt)); sof_q.push_back(sof4); err_q.push_back(len_err);
        end
    endtask

    // kind: 0 idle, 1 data, 2 /S/ lane0, 3 /S/ lane4, 4 /T/ lane k,
    //       5 /T/ lane k<4 plus /S/ lane4, 6 fault lane0, 7 fault lane4
    task automatic make_word(input int kind, input int k, output logic [63:0] d, output logic [7:0] c);
        d = {$urandom, $urandom};
        c = 8'h00;
        case (kind)
            0: begin d = IDLE_D; c = 8'hFF; end
            2: begin d[7:0] = 8'hFB; c = 8'h01; end
            3: begin d[31:0] = 32'h07070707; d[39:32] = 8'hFB; c = 8'h1F; end
            4, 5: begin
                for (int j = 0; j < 8; j++) begin
                    if (j == k) begin d[8*j +: 8] = 8'hFD; c[j] = 1'b1; end
                    else if (j > k) begin d[8*j +: 8] = 8'h07; c[j] = 1'b1; end
                end
                if (kind == 5) d[39:32] = 8'hFB;
            end
            6: begin d = IDLE_D; d[7:0] = 8'h9C; c = 8'hFF; end
            7: begin d = IDLE_D; d[39:32] = 8'h9C; c = 8'hFF; end
            default: ;
        endcase
    endtask

    task automatic send(input logic [1:0] spd, input int kind, input int k);
        logic [63:0] d;
        logic [7:0]  c;
        int          div;
        make_word(kind, k, d, c);
        div = div_of(spd);
        repeat (div) step(spd, d, c);
    endtask

    task automatic send_data(input logic [1:0] spd, input int n);
        for (int i = 0; i < n; i++) send(spd, 1, 0);
    endtask

    task automatic do_reset(input logic [1:0] spd);
        reset = 1'b1; speed_sel = spd; data_in = IDLE_D; ctrl_in = 8'hFF;
        model_reset();
        #1;
        check("rst_data_out", data_out, IDLE_D);
        check("rst_ctrl_out", 64'(ctrl_out), 64'hFF);
        check("rst_we", 64'(we), 64'd0);
        check("rst_byte_cnt", 64'(byte_cnt), 64'd0);
        check("rst_sof4", 64'(sof4), 64'd0);
        check("rst_bcnt_we", 64'(bcnt_we), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        check("rst_linkup", 64'(linkup), 64'd0);
        check("rst_fault_cnt", 64'(fault_cnt), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [1:0] cur_spd;
    int up_at;
    int r;

    initial begin
        reset = 1'b1; speed_sel = 2'b00; data_in = IDLE_D; ctrl_in = 8'hFF;

        // 10G nominal frame
        do_reset(2'b00);
        step(2'b00, IDLE_D, 8'hFF);
        clear_obs();
        send(2'b00, 2, 0); send_data(2'b00, 7); send(2'b00, 4, 4);
        repeat (4) step(2'b00, IDLE_D, 8'hFF);
        check("10g_we_cycles", 64'(we_cnt), 64'd9);
        check("10g_pulses", 64'(bc_cnt), 64'd1);
        if (bc_cnt == 1) begin
            check("10g_byte_cnt", 64'(bc_q[0]), 64'd68);
            check("10g_sof4", 64'(sof_q[0]), 64'd0);
            check("10g_len_err", 64'(err_q[0]), 64'd0);
        end

        // 2.5G, each word held 4 clocks
        do_reset(2'b10);
        step(2'b10, IDLE_D, 8'hFF);
        clear_obs();
        send(2'b10, 2, 0); send_data(2'b10, 7); send(2'b10, 4, 4);
        repeat (8) step(2'b10, IDLE_D, 8'hFF);
        check("2g5_we_pulses", 64'(we_cnt), 64'd9);
        check("2g5_pulses", 64'(bc_cnt), 64'd1);
        if (bc_cnt == 1) check("2g5_byte_cnt", 64'(bc_q[0]), 64'd68);

        // 5G long frame starting on lane 4
        do_reset(2'b01);
        step(2'b01, IDLE_D, 8'hFF);
        clear_obs();
        send(2'b01, 3, 0); send_data(2'b01, 1300); send(2'b01, 4, 0);
        repeat (4) step(2'b01, IDLE_D, 8'hFF);
        check("5g_pulses", 64'(bc_cnt), 64'd1);
        if (bc_cnt == 1) begin
            check("5g_byte_cnt", 64'(bc_q[0]), 64'd10404);
            check("5g_sof4", 64'(sof_q[0]), 64'd1);
            check("5g_len_err", 64'(err_q[0]), 64'd1);
        end

        // /T/ lane 2 and /S/ lane 4 in one word
        do_reset(2'b00);
        step(2'b00, IDLE_D, 8'hFF);
        clear_obs();
        send(2'b00, 2, 0); send_data(2'b00, 8); send(2'b00, 5, 2);
        send_data(2'b00, 8); send(2'b00, 4, 3);
        repeat (3) step(2'b00, IDLE_D, 8'hFF);
        check("ts_pulses", 64'(bc_cnt), 64'd2);
        if (bc_cnt == 2) begin
            check("ts_first_cnt", 64'(bc_q[0]), 64'd74);
            check("ts_first_sof4", 64'(sof_q[0]), 64'd0);
            check("ts_second_cnt", 64'(bc_q[1]), 64'd71);
            check("ts_second_sof4", 64'(sof_q[1]), 64'd1);
        end

        // /S/ inside an open frame
        clear_obs();
        send(2'b00, 2, 0); send_data(2'b00, 10); send(2'b00, 2, 0);
        send_data(2'b00, 7); send(2'b00, 4, 4);
        repeat (3) step(2'b00, IDLE_D, 8'hFF);
        check("ss_pulses", 64'(bc_cnt), 64'd2);
        if (bc_cnt == 2) begin
            check("ss_first_cnt", 64'(bc_q[0]), 64'd88);
            check("ss_first_err", 64'(err_q[0]), 64'd1);
            check("ss_second_cnt", 64'(bc_q[1]), 64'd68);
            check("ss_second_err", 64'(err_q[1]), 64'd0);
        end

        // speed change mid-frame, then reset mid-frame
        clear_obs();
        send(2'b00, 2, 0); send_data(2'b00, 3);
        send(2'b01, 0, 0);
        check("chg_no_pulse", 64'(bc_cnt), 64'd0);
        send(2'b01, 2, 0); send_data(2'b01, 7); send(2'b01, 4, 4);
        repeat (4) step(2'b01, IDLE_D, 8'hFF);
        check("chg_pulses", 64'(bc_cnt), 64'd1);
        if (bc_cnt == 1) check("chg_byte_cnt", 64'(bc_q[0]), 64'd68);
        clear_obs();
        send(2'b01, 2, 0); send_data(2'b01, 3);
        do_reset(2'b01);
        step(2'b01, IDLE_D, 8'hFF);
        check("rstmid_no_pulse", 64'(bc_cnt), 64'd0);
        send(2'b01, 2, 0); send_data(2'b01, 7); send(2'b01, 4, 4);
        repeat (4) step(2'b01, IDLE_D, 8'hFF);
        check("rstmid_pulses", 64'(bc_cnt), 64'd1);
        if (bc_cnt == 1) check("rstmid_byte_cnt", 64'(bc_q[0]), 64'd68);

        // accumulator saturation
        do_reset(2'b00);
        step(2'b00, IDLE_D, 8'hFF);
        clear_obs();
        send(2'b00, 2, 0); send_data(2'b00, 8195); send(2'b00, 4, 0);
        step(2'b00, IDLE_D, 8'hFF);
        check("sat_pulses", 64'(bc_cnt), 64'd1);
        if (bc_cnt == 1) begin
            check("sat_byte_cnt", 64'(bc_q[0]), 64'(CNT_MAX));
            check("sat_len_err", 64'(err_q[0]), 64'd1);
        end

        // 1G link qualification and a single fault
        do_reset(2'b11);
        up_at = -1;
        for (int n = 1; n <= 400 && up_at < 0; n++) begin
            step(2'b11, IDLE_D, 8'hFF);
            if (linkup) up_at = n;
        end
        check("1g_linkup_in_window", 64'((up_at >= 300) && (up_at <= 330)), 64'd1);
        repeat (7) step(2'b11, IDLE_D, 8'hFF);
        send(2'b11, 6, 0);
        check("1g_fault_linkup", 64'(linkup), 64'd0);
        check("1g_fault_cnt", 64'(fault_cnt), 64'd1);

        // randomized traffic with occasional speed changes and resets
        cur_spd = 2'b00;
        do_reset(cur_spd);
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 299) == 0) cur_spd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1999) == 0) do_reset(cur_spd);
            r = $urandom_range(0, 99);
            if (r < 14)      send(cur_spd, 0, 0);
            else if (r < 66) send(cur_spd, 1, 0);
            else if (r < 74) send(cur_spd, 2, 0);
            else if (r < 79) send(cur_spd, 3, 0);
            else if (r < 92) send(cur_spd, 4, $urandom_range(0, 7));
            else if (r < 97) send(cur_spd, 5, $urandom_range(0, 3));
            else if (r < 98) send(cur_spd, 6, 0);
            else if (r < 99) send(cur_spd, 7, 0);
            else             step(cur_spd, {$urandom, $urandom}, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
